// File: rtl/petra_tx_scheduler_pkg.sv
// petra_tx_scheduler_pkg: shared defaults, FSM state encoding and small helpers
// for the petra transmit scheduler.
package petra_tx_scheduler_pkg;

    // Default message width of the petra link.
    localparam int unsigned MESSAGE_SIZE = 8;

    // Scheduler defaults.
    localparam int unsigned PTS_NUM_REQ = 4;
    localparam int unsigned PTS_TIMEOUT = 1024;
    localparam int unsigned PTS_GAP     = 2;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } pts_state_e;

    // Increment an index modulo n (works for non-power-of-2 n).
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/petra_tx_scheduler_if.sv
// petra_tx_scheduler_if: requester-side handshake plus the petra transmit
// signals of the scheduler.
//   req / req_data     : per-requester request level and packed payload bytes
//   grant / done / err : one-hot served requester and completion pulses
//   busy               : scheduler not idle
//   petra_send / petra_data / petra_irq_tx : petra transmitter connection
// slave modport is the scheduler view, master is the client/petra view.
interface petra_tx_scheduler_if
    import petra_tx_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = PTS_NUM_REQ,
    parameter int unsigned MSG_W   = MESSAGE_SIZE
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*MSG_W-1:0] req_data;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic [NUM_REQ-1:0]       err;
    logic                     busy;
    logic                     petra_send;
    logic [MSG_W-1:0]         petra_data;
    logic                     petra_irq_tx;

    modport master (
        output req, req_data, petra_irq_tx,
        input  grant, done, err, busy, petra_send, petra_data
    );

    modport slave (
        input  req, req_data, petra_irq_tx,
        output grant, done, err, busy, petra_send, petra_data
    );
endinterface

// File: rtl/petra_tx_scheduler_rr_pick.sv
// petra_rr_pick: combinational round-robin picker. Returns the first set req
// bit searching upward from ptr with wrap-around.
//   req    : request vector
//   ptr    : round-robin start index (< NUM_REQ)
//   valid  : any request present
//   winner : index of the selected requester
module petra_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] winner
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int unsigned cand;
        valid  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = 32'(ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!valid && req[IDX_W'(cand)]) begin
                valid  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/petra_tx_scheduler.sv
// petra_tx_scheduler: shares one petra transmitter between NUM_REQ requesters.
// Round-robin grant, latched payload byte, send held until irq_tx or timeout,
// one-hot done/err pulse, then an idle gap before the next grant.
//   clock, reset : clock and synchronous active-high reset
//   bus          : slave modport of petra_tx_scheduler_if
module petra_tx_scheduler
    import petra_tx_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = PTS_NUM_REQ,
    parameter int unsigned MSG_W   = MESSAGE_SIZE,
    parameter int unsigned TIMEOUT = PTS_TIMEOUT,
    parameter int unsigned GAP     = PTS_GAP
) (
    input logic                 clock,
    input logic                 reset,
    petra_tx_scheduler_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT);
    localparam int unsigned GCNT_W = $clog2(GAP + 1);

    pts_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic                busy_q, busy_d;
    logic                send_q, send_d;
    logic [MSG_W-1:0]    data_q, data_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [GCNT_W-1:0]   gcnt_q, gcnt_d;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;

    petra_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (bus.req),
        .ptr    (rr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            send_q  <= 1'b0;
            data_q  <= '0;
            win_q   <= '0;
            rr_q    <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            send_q  <= send_d;
            data_q  <= data_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // Next state and next output values.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        send_d  = send_q;
        data_d  = data_q;
        win_d   = win_q;
        rr_d    = rr_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_SEND;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    data_d  = bus.req_data[int'(pick_idx) * MSG_W +: MSG_W];
                    send_d  = 1'b1;
                    win_d   = pick_idx;
                    tcnt_d  = '0;
                end
            end
            ST_SEND: begin
                // irq_tx takes priority over a coinciding timeout.
                if (bus.petra_irq_tx || (tcnt_q == TCNT_W'(TIMEOUT - 1))) begin
                    state_d = ST_GAP;
                    done_d  = bus.petra_irq_tx ? grant_q : '0;
                    err_d   = bus.petra_irq_tx ? '0 : grant_q;
                    send_d  = 1'b0;
                    grant_d = '0;
                    rr_d    = IDX_W'(wrap_inc(32'(win_q), NUM_REQ));
                    gcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gcnt_q == GCNT_W'(GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;
    assign bus.petra_send = send_q;
    assign bus.petra_data = data_q;
endmodule

// File: tb/tb_petra_tx_scheduler.sv
// tb_petra_tx_scheduler: randomized self-checking bench for petra_tx_scheduler
// against a transfer-level reference model (round-robin pick by plain search,
// expected send duration from irq latency vs. timeout).
module tb_petra_tx_scheduler;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned TO = 16;
    localparam int unsigned GP = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   rr_model = 0;
    logic [W-1:0] slot [N];

    petra_tx_scheduler_if #(.NUM_REQ(N), .MSG_W(W)) bus ();

    petra_tx_scheduler #(.NUM_REQ(N), .MSG_W(W), .TIMEOUT(TO), .GAP(GP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_data();
        for (int i = 0; i < int'(N); i++) bus.req_data[i*W +: W] = slot[i];
    endtask

    // Reference arbitration: first requesting index at or above ptr, wrapping.
    function automatic int pick_model(input logic [N-1:0] r, input int ptr);
        for (int off = 0; off < int'(N); off++) begin
            if (r[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    // Drives one transfer: waits for petra_send to rise, raises irq_tx k cycles
    // into SEND, and reports what was observed. The winner drops req on exit.
    task automatic run_xfer(input int k, input bit mutate, input bit drop, input bit pre_irq,
                            output bit rose, output int wait_steps, output int hc,
                            output logic [N-1:0] g_grant, output logic [W-1:0] g_data,
                            output bit stable, output logic [N-1:0] d_x,
                            output logic [N-1:0] e_x, output bit stray);
        int j;
        rose = 0; wait_steps = 0; hc = 0; stable = 1; stray = 0;
        g_grant = '0; g_data = '0; d_x = '0; e_x = '0;
        bus.petra_irq_tx = pre_irq;
        while (!rose && wait_steps < 20) begin
            step();
            wait_steps++;
            if (bus.petra_send === 1'b1) rose = 1;
        end
        if (!rose) begin
            bus.petra_irq_tx = 1'b0;
            return;
        end
        g_grant = bus.grant;
        g_data  = bus.petra_data;
        hc = 1;
        j = 0;
        if (bus.done !== '0 || bus.err !== '0) stray = 1;
        while (j < int'(TO) + 8) begin
            if (j == k) bus.petra_irq_tx = 1'b1;
            if (j == 0 && mutate) bus.req_data = '1;
            if (j == 0 && drop) bus.req = '0;
            step();
            j++;
            if (bus.petra_send !== 1'b1) begin
                d_x = bus.done;
                e_x = bus.err;
                break;
            end
            hc++;
            if (bus.petra_data !== g_data || bus.grant !== g_grant) stable = 0;
            if (bus.done !== '0 || bus.err !== '0) stray = 1;
        end
        bus.petra_irq_tx = 1'b0;
        bus.req = bus.req & ~g_grant;
        step();
        if (bus.done !== '0 || bus.err !== '0 || bus.petra_send !== 1'b0) stray = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.req = '0; bus.req_data = '0; bus.petra_irq_tx = 1'b0;
        step(); step();
        checks++; if (bus.grant !== '0) begin failures++; $display("FAIL reset_grant got=%b exp=0", bus.grant); end
        checks++; if (bus.done !== '0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.err !== '0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.petra_send !== 1'b0) begin failures++; $display("FAIL reset_send got=%b exp=0", bus.petra_send); end
        checks++; if (bus.petra_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.petra_data); end
        reset = 1'b0;
        rr_model = 0;
    endtask

    task automatic test_single();
        bit rose, stable, stray; int ws, hc;
        logic [N-1:0] g, d, e; logic [W-1:0] dat;
        for (int i = 0; i < int'(N); i++) slot[i] = W'($urandom);
        slot[1] = 8'h50;
        drive_data();
        bus.req = 4'b0010;
        run_xfer(3, 0, 0, 0, rose, ws, hc, g, dat, stable, d, e, stray);
        checks++; if (!rose) begin failures++; $display("FAIL single_rose got=0 exp=1"); end
        checks++; if (ws != 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", ws); end
        checks++; if (g !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b exp=0010", g); end
        checks++; if (dat !== 8'h50) begin failures++; $display("FAIL single_data got=%h exp=50", dat); end
        checks++; if (hc != 4) begin failures++; $display("FAIL single_send_len got=%0d exp=4", hc); end
        checks++; if (d !== 4'b0010 || e !== '0) begin failures++; $display("FAIL single_done got=%b/%b exp=0010/0000", d, e); end
        checks++; if (stray || !stable) begin failures++; $display("FAIL single_clean got=%0d/%0d exp=0/1", stray, stable); end
        rr_model = 2;
    endtask

    task automatic test_irq_idle();
        int bad = 0;
        bus.req = '0;
        bus.petra_irq_tx = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.done !== '0 || bus.err !== '0 || bus.petra_send !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        bus.petra_irq_tx = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL irq_idle got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_round_robin();
        bit rose, stable, stray; int ws, hc;
        logic [N-1:0] g, d, e; logic [W-1:0] dat;
        logic [N-1:0] exp_g [4];
        int exp_i [4];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
        exp_i[0] = 0; exp_i[1] = 1; exp_i[2] = 3; exp_i[3] = 0;
        bus.req = '0;
        reset = 1'b1; step(); reset = 1'b0;
        rr_model = 0;
        slot[0] = 8'hA0; slot[1] = 8'hA1; slot[2] = 8'h5A; slot[3] = 8'hA3;
        drive_data();
        for (int i = 0; i < 4; i++) begin
            bus.req = 4'b1011;
            run_xfer(int'($urandom_range(0, 5)), 0, 0, 0, rose, ws, hc, g, dat, stable, d, e, stray);
            checks++; if (g !== exp_g[i]) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, g, exp_g[i]); end
            checks++; if (dat !== slot[exp_i[i]]) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, dat, slot[exp_i[i]]); end
            checks++; if (d !== exp_g[i] || e !== '0) begin failures++; $display("FAIL rr_done[%0d] got=%b/%b exp=%b/0000", i, d, e, exp_g[i]); end
            checks++; if (ws != ((i == 0) ? 1 : int'(GP))) begin failures++; $display("FAIL rr_gap[%0d] got=%0d exp=%0d", i, ws, (i == 0) ? 1 : int'(GP)); end
            rr_model = (exp_i[i] + 1) % N;
        end
    endtask

    task automatic test_timeout();
        bit rose, stable, stray; int ws, hc, w;
        logic [N-1:0] g, d, e; logic [W-1:0] dat;
        for (int i = 0; i < int'(N); i++) slot[i] = W'($urandom);
        drive_data();
        bus.req = 4'b0100;
        w = pick_model(4'b0100, rr_model);
        run_xfer(100000, 0, 0, 0, rose, ws, hc, g, dat, stable, d, e, stray);
        checks++; if (hc != int'(TO)) begin failures++; $display("FAIL timeout_len got=%0d exp=%0d", hc, TO); end
        checks++; if (e !== 4'b0100 || d !== '0) begin failures++; $display("FAIL timeout_err got=%b/%b exp=0100/0000", e, d); end
        checks++; if (stray || !stable) begin failures++; $display("FAIL timeout_clean got=%0d/%0d exp=0/1", stray, stable); end
        rr_model = (w + 1) % N;
        bus.req = 4'b1001;
        w = pick_model(4'b1001, rr_model);
        run_xfer(2, 0, 0, 0, rose, ws, hc, g, dat, stable, d, e, stray);
        checks++; if (g !== 4'b1000) begin failures++; $display("FAIL timeout_next_grant got=%b exp=1000", g); end
        checks++; if (d !== 4'b1000 || hc != 3) begin failures++; $display("FAIL timeout_next_done got=%b len=%0d exp=1000 len=3", d, hc); end
        rr_model = (w + 1) % N;
        bus.req = '0;
    endtask

    task automatic test_coincide();
        bit rose, stable, stray; int ws, hc, w;
        logic [N-1:0] r, g, d, e; logic [W-1:0] dat;
        for (int t = 0; t < 2; t++) begin
            r = N'($urandom_range(1, 15));
            bus.req = r;
            w = pick_model(r, rr_model);
            // t=0: irq lands exactly on the last allowed cycle; t=1: one cycle late.
            run_xfer(int'(TO) - 1 + t, 0, 0, 0, rose, ws, hc, g, dat, stable, d, e, stray);
            checks++; if (hc != int'(TO)) begin failures++; $display("FAIL coincide_len[%0d] got=%0d exp=%0d", t, hc, TO); end
            if (t == 0) begin
                checks++; if (d !== N'(1 << w) || e !== '0) begin failures++; $display("FAIL coincide_done got=%b/%b exp=%b/0000", d, e, N'(1 << w)); end
            end else begin
                checks++; if (e !== N'(1 << w) || d !== '0) begin failures++; $display("FAIL late_irq_err got=%b/%b exp=%b/0000", e, d, N'(1 << w)); end
            end
            rr_model = (w + 1) % N;
            bus.req = '0;
        end
    endtask

    task automatic test_mid_op();
        bit rose, stable, stray; int ws, hc, w;
        logic [N-1:0] g, d, e; logic [W-1:0] dat;
        for (int i = 0; i < int'(N); i++) slot[i] = W'($urandom_range(0, 254));
        drive_data();
        bus.req = 4'b1111;
        w = pick_model(4'b1111, rr_model);
        run_xfer(4, 1, 1, 0, rose, ws, hc, g, dat, stable, d, e, stray);
        checks++; if (dat !== slot[w] || !stable) begin failures++; $display("FAIL midop_data got=%h stable=%0d exp=%h stable=1", dat, stable, slot[w]); end
        checks++; if (d !== N'(1 << w) || e !== '0) begin failures++; $display("FAIL midop_done got=%b/%b exp=%b/0000", d, e, N'(1 << w)); end
        rr_model = (w + 1) % N;
        drive_data();
    endtask

    task automatic test_mid_reset();
        bit rose, stable, stray; int ws, hc, n;
        logic [N-1:0] g, d, e; logic [W-1:0] dat;
        bus.req = 4'b1111;
        n = 0;
        while (bus.petra_send !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (bus.petra_send !== 1'b1) begin failures++; $display("FAIL mreset_start got=%b exp=1", bus.petra_send); end
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.grant !== '0 || bus.done !== '0 || bus.err !== '0) begin failures++; $display("FAIL mreset_handshake got=%b/%b/%b exp=0/0/0", bus.grant, bus.done, bus.err); end
        checks++; if (bus.petra_send !== 1'b0 || bus.busy !== 1'b0 || bus.petra_data !== '0) begin failures++; $display("FAIL mreset_petra got=%b/%b/%h exp=0/0/00", bus.petra_send, bus.busy, bus.petra_data); end
        rr_model = 0;
        run_xfer(1, 0, 0, 0, rose, ws, hc, g, dat, stable, d, e, stray);
        checks++; if (g !== 4'b0001 || ws != 1) begin failures++; $display("FAIL mreset_first got=%b wait=%0d exp=0001 wait=1", g, ws); end
        checks++; if (d !== 4'b0001 || stray) begin failures++; $display("FAIL mreset_done got=%b stray=%0d exp=0001 stray=0", d, stray); end
        rr_model = 1;
    endtask

    task automatic test_back_to_back();
        bit rose, stable, stray, pre; int ws, hc, w, k, exp_hc;
        logic [N-1:0] r, g, d, e, exp_d, exp_e; logic [W-1:0] dat;
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < int'(N); i++) slot[i] = W'($urandom);
            drive_data();
            r = N'($urandom_range(1, 15));
            bus.req = r;
            pre = ($urandom_range(0, 5) == 0);
            k = pre ? 0 : int'($urandom_range(0, TO + 2));
            w = pick_model(r, rr_model);
            exp_hc = (k <= int'(TO) - 1) ? k + 1 : int'(TO);
            exp_d = (k <= int'(TO) - 1) ? N'(1 << w) : '0;
            exp_e = (k <= int'(TO) - 1) ? '0 : N'(1 << w);
            run_xfer(k, 0, 0, pre, rose, ws, hc, g, dat, stable, d, e, stray);
            checks++; if (!rose || ws != int'(GP)) begin failures++; $display("FAIL b2b_gap[%0d] got=%0d rose=%0d exp=%0d", t, ws, rose, GP); end
            checks++; if (g !== N'(1 << w) || dat !== slot[w]) begin failures++; $display("FAIL b2b_pick[%0d] got=%b/%h exp=%b/%h", t, g, dat, N'(1 << w), slot[w]); end
            checks++; if (hc != exp_hc) begin failures++; $display("FAIL b2b_len[%0d] got=%0d exp=%0d", t, hc, exp_hc); end
            checks++; if (d !== exp_d || e !== exp_e) begin failures++; $display("FAIL b2b_result[%0d] got=%b/%b exp=%b/%b", t, d, e, exp_d, exp_e); end
            checks++; if (stray || !stable) begin failures++; $display("FAIL b2b_clean[%0d] got=%0d/%0d exp=0/1", t, stray, stable); end
            rr_model = (w + 1) % N;
            bus.req = '0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_irq_idle();
        test_round_robin();
        test_timeout();
        test_coincide();
        test_mid_op();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/petra_tx_scheduler.md
Name: petra_tx_scheduler

Overview:
- Shares one petra optical link transmitter between NUM_REQ local requesters.
- Picks requesters round-robin and latches the winner's byte onto petra data_in.
- Holds petra send_message high until petra irq_tx reports completion, or until a timeout expires.
- Returns a one-hot done or err pulse to the winner, then enforces an idle gap before the next grant.
- Sits between client logic and a single petra instance; the receive path is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MSG_W, `MESSAGE_SIZE (8), message width in bits.
- TIMEOUT, 1024, maximum cycles petra_send stays high without irq_tx before abort (>=2).
- GAP, 2, cycles petra_send is held low after each transfer before the next grant (>=1).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester transmit request; level, held until own done/err.
- req_data  in  NUM_REQ*MSG_W  packed bytes; requester i occupies bits [i*MSG_W +: MSG_W].
- grant  out  NUM_REQ  one-hot, currently served requester; 0 when idle.
- done  out  NUM_REQ  one-hot, single-cycle pulse on successful transfer.
- err  out  NUM_REQ  one-hot, single-cycle pulse on timeout abort.
- busy  out  1  high in any state other than IDLE.
- petra_send  out  1  drives petra send_message.
- petra_data  out  MSG_W  drives petra data_in; stable while petra_send is high.
- petra_irq_tx  in  1  petra irq_tx (transfer complete).

Behaviour:
- Reset values (applied at the next edge while reset=1, from any state):
  - grant=0, done=0, err=0, busy=0, petra_send=0, petra_data=0.
  - State IDLE, rr pointer=0, counters=0.
  - A transfer in progress is dropped; no done/err is issued for it.
- States: IDLE, SEND, GAP.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching upward from the rr pointer, with wrap-around.
  - Next edge: state=SEND, grant=onehot(winner), petra_data=req_data slice of winner, petra_send=1, timeout count=0.
  - Latency: req sampled at edge t gives petra_send=1 after edge t+1.
- SEND:
  - petra_data and grant are frozen. Changes to req or req_data during the transfer are ignored.
  - A requester dropping req mid-transfer does not abort the transfer.
  - If petra_irq_tx=1: the next edge gives done=grant (1 cycle), petra_send=0, grant=0, rr pointer=winner+1 mod NUM_REQ, state=GAP, gap count=0.
  - Else if the count reaches TIMEOUT-1: same exit, but err=grant instead of done.
  - Else the count increments.
  - If irq_tx and the timeout coincide in the same cycle, success wins: done is pulsed, err is not.
- GAP:
  - petra_send=0, grant=0, busy=1.
  - After GAP cycles the state goes to IDLE.
  - req is not sampled during GAP.
  - Minimum spacing between two petra_send rising edges is GAP+2 cycles after completion.
- petra_irq_tx is ignored outside SEND. If it is already high when SEND is entered, the transfer completes after one cycle.
- Fairness: a requester holding req continuously waits at most NUM_REQ-1 other transfers.
- Counter widths:
  - Timeout counter: $clog2(TIMEOUT) bits, saturating, no wrap.
  - Gap counter: $clog2(GAP+1) bits.
  - rr pointer: $clog2(NUM_REQ) bits; wraps at NUM_REQ, including for non-power-of-2 NUM_REQ.
- done and err are never both set, and never set outside the cycle that follows the SEND exit.

Decomposition:
- definitions.v gains:
  - State encodings `PTS_IDLE, `PTS_SEND, `PTS_GAP (2 bits).
  - Default macros `PTS_TIMEOUT and `PTS_GAP.
  - MSG_W continues to default to `MESSAGE_SIZE.
- One sub-module, petra_rr_pick:
  - Purely combinational.
  - Inputs: req vector and rr pointer.
  - Outputs: valid and winner index.
  - Verified standalone before integration.

Test Plan:
- Single request: reset, req=4'b0010, req_data slot1=8'h50, petra2 receiving. Expect petra_send=1 and petra_data=8'h50 one cycle after req; done=4'b0010 pulses once the cycle after irq_tx; petra2 data_out=8'h50 with irq_rx=1.
- Round-robin: req=4'b1011 held, with bytes 8'hA0/8'hA1/—/8'hA3. Expect grant order 0001, 0010, 1000, 0001. Each transfer is separated by >=GAP cycles of petra_send=0.
- Timeout: petra_irq_tx tied 0, TIMEOUT=16, req=4'b0100. Expect petra_send high exactly 16 cycles, then err=4'b0100 for 1 cycle and done=0. The next grant goes to requester 3 if requested.
- Coincidence: force irq_tx=1 on the cycle the count reaches TIMEOUT-1. Expect done pulse and no err.
- Mid-op events: req_data changes to 8'hFF during SEND, so petra_data must stay at the original byte; req is dropped during SEND, and done must still pulse.
- Mid-op reset: reset=1 for 1 cycle mid-SEND. At the next edge all outputs are 0 with no done/err; after reset, requester 0 is served first.
